uart_frame_parser: RTL and testbench

Downstream consumer of the UART receive path. Takes the byte stream and one-cycle `uart_done` strobes from `uart_rx`, and recognises frames of the form header, length, payload, checksum. It buffers the payload and releases a checksum-verified payload through a valid/ready byte stream. Malformed or failed frames raise an error pulse with a code; the host logic never sees bytes from a bad frame.

---
 rtl/uart_frame_pkg.sv | 18 +
 rtl/uart_frame_parser_if.sv | 26 ++
 rtl/uart_frame_buf.sv | 24 ++
 rtl/uart_frame_parser.sv | 177 +++++++++++++++++
 tb/tb_uart_frame_parser.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame parser: FSM state encoding, error codes and default header.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StPayload,
    StCsum,
    StDrain
  } state_e;

  localparam logic [1:0] ERR_BAD_LEN  = 2'd1;
  localparam logic [1:0] ERR_BAD_CSUM = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

endpackage

// File: rtl/uart_frame_parser_if.sv
// Byte-in / payload-out signal bundle of the frame parser; slave is the parser, master the host.
interface uart_frame_parser_if;

  logic [7:0] uart_data_in;
  logic       uart_done;
  logic [7:0] pay_data;
  logic       pay_valid;
  logic       pay_ready;
  logic       pay_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       overrun;
  logic       busy;

  modport slave (
    input  uart_data_in, uart_done, pay_ready,
    output pay_data, pay_valid, pay_last, frame_ok, frame_err, err_code, overrun, busy
  );

  modport master (
    output uart_data_in, uart_done, pay_ready,
    input  pay_data, pay_valid, pay_last, frame_ok, frame_err, err_code, overrun, busy
  );

endinterface

// File: rtl/uart_frame_buf.sv
// Payload buffer: Depth x 8 register array, one write port, combinational read port, no reset.
module uart_frame_buf #(
  parameter int unsigned Depth = 16,
  parameter int unsigned PtrW  = 4
) (
  input  logic            clk,
  input  logic            we,
  input  logic [PtrW-1:0] wr_ptr,
  input  logic [7:0]      wdata,
  input  logic [PtrW-1:0] rd_ptr,
  output logic [7:0]      rdata
);

  logic [7:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_ptr] <= wdata;
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/uart_frame_parser.sv
// Frame recogniser (header, length, payload, checksum) with buffered, verified payload release.
// Optional inter-byte timeout is compiled in with UART_FRAME_TIMEOUT_EN.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter logic [7:0]  HEADER         = DEFAULT_HEADER,
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_frame_parser_if.slave bus
);

  localparam int unsigned CntW = $clog2(MAX_LEN + 1);
  localparam int unsigned PtrW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_e          state_q, state_d;
  logic [CntW-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [7:0]      acc_q, acc_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic            ok_q, ok_d, err_q, err_d, ovr_q, ovr_d;
  logic [1:0]      code_q, code_d;
  logic            buf_we;
  logic [7:0]      buf_rdata, sum;
  logic            len_ok, pay_valid, pay_last, timeout;

  uart_frame_buf #(
    .Depth (MAX_LEN),
    .PtrW  (PtrW)
  ) u_buf (
    .clk    (clk),
    .we     (buf_we),
    .wr_ptr (cnt_q[PtrW-1:0]),
    .wdata  (bus.uart_data_in),
    .rd_ptr (rd_ptr_q),
    .rdata  (buf_rdata)
  );

  assign len_ok    = (bus.uart_data_in != 8'd0) && (32'(bus.uart_data_in) <= MAX_LEN);
  assign pay_valid = (state_q == StDrain);
  assign pay_last  = pay_valid && (CntW'(rd_ptr_q) == len_q - 1'b1);

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int unsigned TmrW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TmrW-1:0] tmr_q, tmr_d;
  logic            armed;

  assign armed   = state_q inside {StLen, StPayload, StCsum};
  // A byte on the expiry edge wins over the timeout.
  assign timeout = armed && !bus.uart_done && (tmr_q == TmrW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmr_d = '0;
    if (armed && !bus.uart_done && (state_d == state_q)) begin
      tmr_d = tmr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rd_ptr_d = rd_ptr_q;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    code_d   = 2'd0;
    ovr_d    = 1'b0;
    buf_we   = 1'b0;
    sum      = acc_q + bus.uart_data_in;
    unique case (state_q)
      StIdle: begin
        if (bus.uart_done && (bus.uart_data_in == HEADER)) state_d = StLen;
      end
      StLen: begin
        if (bus.uart_done) begin
          if (len_ok) begin
            len_d   = bus.uart_data_in[CntW-1:0];
            cnt_d   = '0;
            acc_d   = bus.uart_data_in;
            state_d = StPayload;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_BAD_LEN;
            state_d = StIdle;
          end
        end
      end
      StPayload: begin
        if (bus.uart_done) begin
          buf_we = 1'b1;
          acc_d  = sum;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_d == len_q) state_d = StCsum;
        end
      end
      StCsum: begin
        if (bus.uart_done) begin
          if (sum == 8'd0) begin
            ok_d     = 1'b1;
            rd_ptr_d = '0;
            state_d  = StDrain;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_BAD_CSUM;
            state_d = StIdle;
          end
        end
      end
      StDrain: begin
        ovr_d = bus.uart_done;
        if (bus.pay_ready) begin
          if (pay_last) begin
            rd_ptr_d = '0;
            state_d  = StIdle;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (timeout) begin
      err_d   = 1'b1;
      code_d  = ERR_TIMEOUT;
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      len_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      rd_ptr_q <= '0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= 2'd0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rd_ptr_q <= rd_ptr_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      code_q   <= code_d;
      ovr_q    <= ovr_d;
    end
  end

  // Buffer is never reset, so mask the read port outside DRAIN.
  assign bus.pay_data  = pay_valid ? buf_rdata : 8'h00;
  assign bus.pay_valid = pay_valid;
  assign bus.pay_last  = pay_last;
  assign bus.frame_ok  = ok_q;
  assign bus.frame_err = err_q;
  assign bus.err_code  = code_q;
  assign bus.overrun   = ovr_q;
  assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_frame_parser.sv
// Randomized self-checking bench for uart_frame_parser against a frame-level reference model.
module tb_uart_frame_parser;

  localparam int unsigned MAX_LEN = 16;
  localparam logic [7:0]  HDR     = 8'hA5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  uart_frame_parser_if bus ();

  uart_frame_parser #(
    .HEADER         (HDR),
    .MAX_LEN        (MAX_LEN),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: collects results and checks cycle-level stream rules.
  int         ev_q[$];
  logic [8:0] pay_q[$];
  int         ov_cnt = 0;
  int         pv_cycles = 0;
  logic       pv_prev = 1'b0, rdy_prev = 1'b0, lastx_prev = 1'b0;
  logic [8:0] dat_prev = '0;

  always @(negedge clk) begin
    int npulse;
    npulse = int'(bus.frame_ok) + int'(bus.frame_err) + int'(bus.overrun);
    if (npulse != 0) chk("pulse_excl", 32'(npulse <= 1), 1);
    if (bus.frame_ok) ev_q.push_back(0);
    if (bus.frame_err) ev_q.push_back(int'(bus.err_code));
    if (bus.overrun) ov_cnt++;
    if (bus.pay_valid) pv_cycles++;
    if (bus.pay_valid && !pv_prev) chk("ok_with_valid", 32'(bus.frame_ok), 1);
    if (pv_prev && !rdy_prev && bus.pay_valid)
      chk("hold_stall", {23'd0, bus.pay_last, bus.pay_data}, {23'd0, dat_prev});
    if (lastx_prev) chk("busy_drop", 32'(bus.busy), 0);
    if (bus.pay_valid && bus.pay_ready) pay_q.push_back({bus.pay_last, bus.pay_data});
    lastx_prev = bus.pay_valid && bus.pay_ready && bus.pay_last;
    pv_prev    = bus.pay_valid;
    rdy_prev   = bus.pay_ready;
    dat_prev   = {bus.pay_last, bus.pay_data};
  end

  // Ready driver; mode 1 randomizes, mode 0 leaves pay_ready to the main sequence.
  int rdy_mode = 0;
  initial begin
    bus.pay_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) bus.pay_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.uart_data_in = b;
    bus.uart_done    = 1'b1;
    @(posedge clk);
    #1;
    bus.uart_done    = 1'b0;
    bus.uart_data_in = 8'($urandom);
  endtask

  logic [7:0] nz[$];
  logic [7:0] pl[$];

  // Reference: 0 = frame accepted, else the expected error code.
  function automatic int exp_code(input int len, input int cs);
    int s;
    if (len < 1 || len > int'(MAX_LEN)) return 1;
    s = len + cs;
    foreach (pl[i]) s += int'(pl[i]);
    return (s % 256 == 0) ? 0 : 2;
  endfunction

  task automatic run_frame(input int len, input int cs, input int gmax);
    int code, base_ov;
    ev_q.delete();
    pay_q.delete();
    pv_cycles = 0;
    base_ov   = ov_cnt;
    code      = exp_code(len, cs);
    foreach (nz[i]) begin
      idle($urandom_range(0, gmax));
      send_byte(nz[i]);
    end
    idle($urandom_range(0, gmax));
    send_byte(HDR);
    idle($urandom_range(0, gmax));
    send_byte(8'(len));
    if (code != 1) begin
      foreach (pl[i]) begin
        idle($urandom_range(0, gmax));
        send_byte(pl[i]);
      end
      idle($urandom_range(0, gmax));
      send_byte(8'(cs));
    end
    for (int i = 0; i < 20 && ev_q.size() == 0; i++) idle(1);
    chk("event_seen", 32'(ev_q.size()), 1);
    if (ev_q.size() != 0) chk("event_code", 32'(ev_q[0]), 32'(code));
    if (code == 0) begin
      for (int i = 0; i < 400 && pay_q.size() < len; i++) idle(1);
      chk("pay_count", 32'(pay_q.size()), 32'(len));
      for (int i = 0; i < len && i < pay_q.size(); i++)
        chk("pay_byte", {23'd0, pay_q[i]}, {23'd0, (i == len - 1), pl[i]});
    end else begin
      idle(3);
      chk("no_payload", 32'(pv_cycles), 0);
    end
    idle(2);
    chk("busy_idle", 32'(bus.busy), 0);
    chk("overrun_none", 32'(ov_cnt - base_ov), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {17'd0, bus.pay_data, bus.pay_valid, bus.pay_last, bus.frame_ok, bus.frame_err,
              bus.err_code, bus.overrun, bus.busy}, 0);
  endtask

  initial begin
    int base_ov;
    bus.uart_data_in = 8'h00;
    bus.uart_done    = 1'b0;
    #1;
    chk_all_zero("reset_outputs");
    idle(3);
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset_outputs");
    @(posedge clk);
    #1;

    // Basic frame with cycle-level timing checks.
    ev_q.delete();
    pay_q.delete();
    send_byte(HDR); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22); send_byte(8'hCB);
    @(negedge clk);
    chk("t1_ok", 32'(bus.frame_ok), 1);
    chk("t1_first", {22'd0, bus.pay_valid, bus.pay_last, bus.pay_data}, {22'd0, 2'b10, 8'h11});
    @(negedge clk);
    chk("t1_ok_pulse", 32'(bus.frame_ok), 0);
    chk("t1_second", {22'd0, bus.pay_valid, bus.pay_last, bus.pay_data}, {22'd0, 2'b11, 8'h22});
    @(negedge clk);
    chk("t1_done", {30'd0, bus.pay_valid, bus.busy}, 0);
    @(posedge clk);
    #1;

    // Noise before a single-byte frame.
    nz = '{8'h00, 8'hFF, 8'hA4};
    pl = '{8'h7F};
    run_frame(1, 8'h80, 0);
    nz.delete();

    // Length out of range at both ends.
    pl.delete();
    run_frame(0, 0, 0);
    run_frame(17, 0, 0);

    // Bad checksum then the same frame with a good one.
    pl = '{8'h11, 8'h22};
    run_frame(2, 8'hCC, 0);
    run_frame(2, 8'hCB, 0);

    // Stalled drain with a byte arriving mid-drain.
    ev_q.delete();
    pay_q.delete();
    base_ov = ov_cnt;
    bus.pay_ready = 1'b0;
    send_byte(HDR); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22); send_byte(8'hCB);
    repeat (3) begin
      @(negedge clk);
      chk("stall_data", {23'd0, bus.pay_last, bus.pay_data}, {23'd0, 1'b0, 8'h11});
    end
    @(posedge clk);
    #1;
    send_byte(8'h55);
    @(negedge clk);
    chk("overrun_pulse", 32'(bus.overrun), 1);
    chk("overrun_data", {24'd0, bus.pay_data}, 32'h11);
    @(posedge clk);
    #1;
    bus.pay_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.pay_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("stall_last", {23'd0, bus.pay_last, bus.pay_data}, {23'd0, 1'b1, 8'h22});
    end
    @(posedge clk);
    #1;
    bus.pay_ready = 1'b1;
    idle(3);
    chk("drain_count", 32'(pay_q.size()), 2);
    if (pay_q.size() == 2) begin
      chk("drain_b0", {23'd0, pay_q[0]}, {23'd0, 9'h011});
      chk("drain_b1", {23'd0, pay_q[1]}, {23'd0, 9'h122});
    end
    chk("overrun_count", 32'(ov_cnt - base_ov), 1);
    chk("drain_busy", 32'(bus.busy), 0);

    // Reset in the middle of the payload.
    ev_q.delete();
    send_byte(HDR); send_byte(8'h03); send_byte(8'h11);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midframe_reset");
    @(negedge clk);
    chk_all_zero("midframe_reset_hold");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    chk("reset_no_event", 32'(ev_q.size()), 0);
    pl = '{8'h11, 8'h22};
    run_frame(2, 8'hCB, 0);

`ifdef UART_FRAME_TIMEOUT_EN
    begin
      int wait_n;
      ev_q.delete();
      send_byte(HDR); send_byte(8'h03); send_byte(8'h11);
      wait_n = -1;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (bus.frame_err) begin
          wait_n = i;
          break;
        end
      end
      chk("timeout_delay", 32'(wait_n), 100);
      chk("timeout_code", 32'(bus.err_code), 3);
      @(posedge clk);
      #1;
      idle(1);
      chk("timeout_idle", 32'(bus.busy), 0);
      run_frame(2, 8'hCB, 0);
    end
`endif

    // Randomized frames with random gaps and back-pressure.
    rdy_mode = 1;
    for (int f = 0; f < 40; f++) begin
      int kind, len, cs, s;
      logic [7:0] b;
      kind = $urandom_range(0, 3);
      nz.delete();
      pl.delete();
      repeat ($urandom_range(0, 3)) begin
        b = 8'($urandom);
        if (b == HDR) b = 8'h00;
        nz.push_back(b);
      end
      if (kind == 2) len = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(MAX_LEN + 1, 255);
      else len = $urandom_range(1, MAX_LEN);
      if (kind != 2) repeat (len) pl.push_back(8'($urandom));
      s = len;
      foreach (pl[i]) s += int'(pl[i]);
      cs = (256 - (s % 256)) % 256;
      if (kind == 3) cs = (cs + $urandom_range(1, 255)) % 256;
      run_frame(len, cs, 3);
    end
    rdy_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
